if_fetch_ctrl: RTL and testbench
================================

# if_fetch_ctrl

Instruction-fetch controller between the IF stage and the instruction memory port (ROM/DRAM behind a variable-latency handshake). It takes the IF stage's fetch address, issues one request at a time to memory, and holds the returned word. It presents the word as the IF stage's instruction input and raises a stall to the core until the word matching the current PC is available. It also discards responses made stale by a PC change while a request is in flight, and keeps fetch/discard counters for IPC analysis.

## Interface
- XLEN, 32, address and instruction width.
- MISALIGN_INST, 32'h0000_0013, word returned (without a memory access) for a PC with pc_in[1:0] != 0.

- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_in  in  XLEN  fetch address from the IF stage (its IM_address).
- inst_out  out  XLEN  instruction to the IF stage (its IM_out); reset 0.
- fetch_stall  out  1  core stall request, high while inst_out is not valid for pc_in; reset 1.
- mem_req  out  1  request valid; reset 0.
- mem_addr  out  XLEN  request address, stable while mem_req=1; reset 0.
- mem_ready  in  1  memory accepts the request when mem_req & mem_ready.
- mem_rvalid  in  1  read data valid, one pulse per accepted request.
- mem_rdata  in  XLEN  read data.
- fetch_count  out  32  accepted requests; reset 0.
- discard_count  out  32  discarded responses; reset 0.

## Operation
- Internal registers:
  - req_addr: address of the request in flight.
  - buf_addr / buf_data: last delivered word; buf_data resets to 0.
  - state: IDLE, REQ, WAIT, VALID; resets to IDLE.
- IDLE:
  - fetch_stall=1, mem_req=0.
  - Next cycle goes to REQ with req_addr<=pc_in.
- REQ:
  - mem_req=1, mem_addr=req_addr.
  - On mem_req & mem_ready: go to WAIT and increment fetch_count.
  - mem_req is never withdrawn and mem_addr never changes before acceptance, even if pc_in changes.
- WAIT:
  - mem_req=0; waits for mem_rvalid.
  - On mem_rvalid with req_addr==pc_in: buf_data<=mem_rdata, buf_addr<=req_addr, go to VALID.
  - On mem_rvalid with req_addr!=pc_in (stale): drop the data, increment discard_count, go to REQ with req_addr<=pc_in.
- VALID:
  - If pc_in==buf_addr: fetch_stall=0 and inst_out=buf_data; stay in VALID while the PC is held.
  - If pc_in!=buf_addr: fetch_stall=1 and go to REQ with req_addr<=pc_in.
- Misaligned PC:
  - If pc_in[1:0]!=0 in IDLE or VALID, no request is issued.
  - buf_data<=MISALIGN_INST and buf_addr<=pc_in; enter VALID the next cycle.
- inst_out is always driven from buf_data. Consumers must ignore it while fetch_stall=1.
- mem_rvalid is ignored in IDLE, REQ and VALID. This covers a late response after reset or a protocol error; it is not counted.
- Counters wrap modulo 2^32. Both increment independently in the same cycle if required.
- rst in any state:
  - Next cycle state=IDLE and mem_req=0, even during a pending REQ.
  - An outstanding memory response is ignored.
  - Counters and buf_data are cleared to 0.

## Timing
- Edge numbering: PC change seen at edge t. Cycle t = VALID with mismatch (fetch_stall=1).
- Cycle t+1: REQ, mem_req=1.
- If mem_ready is asserted in cycle t+1: WAIT in cycle t+2.
- mem_rvalid arrives no earlier than the cycle after acceptance.
- With rvalid in cycle t+2: VALID in cycle t+3, fetch_stall=0.
- Minimum penalty is 3 stall cycles per new PC. Each extra cycle of mem_ready-low or rvalid delay adds one cycle.
- After reset release (first cycle rst=0, state IDLE): mem_req first asserts 1 cycle later. Earliest fetch_stall=0 is 3 cycles after release.
- Misaligned PC: fetch_stall=1 for exactly 1 cycle, then MISALIGN_INST is delivered.
- Outputs are registered state decodes plus the pc_in==buf_addr comparison. The path from pc_in to fetch_stall is combinational.

## Test plan
- Reset with pc_in=0, memory ready always, rvalid 1 cycle after accept, rdata=32'h0010_0093 → mem_req high in cycle 1 with mem_addr=0; fetch_stall low in cycle 3; inst_out=32'h0010_0093; fetch_count=1.
- Sequential PCs 0,4,8 with the bench holding PC while fetch_stall=1 and mem_ready held low 2 extra cycles on the addr-4 request → mem_addr stable at 4 during backpressure; each instruction delivered; fetch_count=3; discard_count=0.
- pc_in changes 0x10→0x80 while in WAIT (redirect) → response for 0x10 discarded; discard_count=1; new request to 0x80; inst_out = data for 0x80 only.
- pc_in=0x22 → no mem_req; after 1 stall cycle inst_out=32'h0000_0013 and fetch_stall=0.
- rst asserted in WAIT, then mem_rvalid pulses during the following IDLE → response ignored; counters 0; fetch_stall=1; fresh request to the current pc_in.
- PC held for 20 cycles in VALID → no extra requests; fetch_count unchanged; inst_out stable.

Source files
------------

// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory request/response bus between the fetch controller (master)
// and a variable-latency memory (slave).
interface if_fetch_ctrl_if #(
  parameter int XLEN = 32
);
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_ready;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ready,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ready,
    output mem_rvalid,
    output mem_rdata
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: one outstanding memory request, a one-word
// delivery buffer, stale-response discard and fetch/discard statistics.
module if_fetch_ctrl #(
  parameter int               XLEN          = 32,
  parameter logic [XLEN-1:0]  MISALIGN_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   pc_in,
  output logic [XLEN-1:0]   inst_out,
  output logic              fetch_stall,
  if_fetch_ctrl_if.master   mem,
  output logic [31:0]       fetch_count,
  output logic [31:0]       discard_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_VALID = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   req_addr_q, req_addr_d;
  logic [XLEN-1:0]   buf_addr_q, buf_addr_d;
  logic [XLEN-1:0]   buf_data_q, buf_data_d;
  logic [31:0]       fetch_count_q, fetch_count_d;
  logic [31:0]       discard_count_q, discard_count_d;

  logic              pc_misaligned;
  logic              buf_hit;

  assign pc_misaligned = (pc_in[1:0] != 2'b00);
  assign buf_hit       = (pc_in == buf_addr_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      req_addr_q      <= '0;
      buf_addr_q      <= '0;
      buf_data_q      <= '0;
      fetch_count_q   <= '0;
      discard_count_q <= '0;
    end else begin
      state_q         <= state_d;
      req_addr_q      <= req_addr_d;
      buf_addr_q      <= buf_addr_d;
      buf_data_q      <= buf_data_d;
      fetch_count_q   <= fetch_count_d;
      discard_count_q <= discard_count_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    req_addr_d      = req_addr_q;
    buf_addr_d      = buf_addr_q;
    buf_data_d      = buf_data_q;
    fetch_count_d   = fetch_count_q;
    discard_count_d = discard_count_q;

    case (state_q)
      ST_IDLE: begin
        if (pc_misaligned) begin
          buf_data_d = MISALIGN_INST;
          buf_addr_d = pc_in;
          state_d    = ST_VALID;
        end else begin
          req_addr_d = pc_in;
          state_d    = ST_REQ;
        end
      end

      // The request is held unchanged until accepted, whatever pc_in does.
      ST_REQ: begin
        if (mem.mem_ready) begin
          fetch_count_d = fetch_count_q + 32'd1;
          state_d       = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (mem.mem_rvalid) begin
          if (req_addr_q == pc_in) begin
            buf_data_d = mem.mem_rdata;
            buf_addr_d = req_addr_q;
            state_d    = ST_VALID;
          end else begin
            discard_count_d = discard_count_q + 32'd1;
            req_addr_d      = pc_in;
            state_d         = ST_REQ;
          end
        end
      end

      ST_VALID: begin
        if (!buf_hit) begin
          if (pc_misaligned) begin
            buf_data_d = MISALIGN_INST;
            buf_addr_d = pc_in;
          end else begin
            req_addr_d = pc_in;
            state_d    = ST_REQ;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Stall is the only output with a combinational path from pc_in.
  assign fetch_stall   = !((state_q == ST_VALID) && buf_hit);
  assign inst_out      = buf_data_q;
  assign mem.mem_req   = (state_q == ST_REQ);
  assign mem.mem_addr  = req_addr_q;
  assign fetch_count   = fetch_count_q;
  assign discard_count = discard_count_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl with a small single-outstanding memory responder.
module tb_if_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic [31:0] inst_out;
  logic        fetch_stall;
  logic [31:0] fetch_count;
  logic [31:0] discard_count;

  if_fetch_ctrl_if #(.XLEN(32)) mif ();

  if_fetch_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .pc_in         (pc_in),
    .inst_out      (inst_out),
    .fetch_stall   (fetch_stall),
    .mem           (mif),
    .fetch_count   (fetch_count),
    .discard_count (discard_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // responder state
  logic        pend;
  logic [31:0] pend_addr;
  int          pend_cnt;
  int          resp_delay;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    if (a == 32'h0) return 32'h0010_0093;
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; memory responds resp_delay cycles after acceptance.
  task automatic tick();
    if (mif.mem_req && mif.mem_ready) begin
      pend      = 1'b1;
      pend_addr = mif.mem_addr;
      pend_cnt  = resp_delay;
    end
    @(posedge clk);
    #1;
    mif.mem_rvalid = 1'b0;
    if (pend) begin
      if (pend_cnt <= 1) begin
        mif.mem_rvalid = 1'b1;
        mif.mem_rdata  = mdata(pend_addr);
        pend           = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (fetch_stall && n < max) begin
      tick();
      n++;
    end
    chk("wait_valid_stall", {31'd0, fetch_stall}, 32'd0);
  endtask

  int n;
  logic [31:0] held_inst;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst            = 1'b1;
    pc_in          = 32'h0;
    mif.mem_ready  = 1'b1;
    mif.mem_rvalid = 1'b0;
    mif.mem_rdata  = 32'h0;
    pend           = 1'b0;
    pend_addr      = 32'h0;
    pend_cnt       = 0;
    resp_delay     = 1;

    tick();
    tick();
    chk("rst_stall",    {31'd0, fetch_stall}, 32'd1);
    chk("rst_mem_req",  {31'd0, mif.mem_req}, 32'd0);
    chk("rst_inst",     inst_out, 32'h0);
    chk("rst_fcount",   fetch_count, 32'd0);
    chk("rst_dcount",   discard_count, 32'd0);

    // reset release: cycle 0 IDLE, cycle 1 REQ, cycle 3 delivered
    rst = 1'b0;
    #1;
    chk("c0_mem_req",   {31'd0, mif.mem_req}, 32'd0);
    tick();
    chk("c1_mem_req",   {31'd0, mif.mem_req}, 32'd1);
    chk("c1_mem_addr",  mif.mem_addr, 32'h0);
    tick();
    chk("c2_stall",     {31'd0, fetch_stall}, 32'd1);
    chk("c2_fcount",    fetch_count, 32'd1);
    tick();
    chk("c3_stall",     {31'd0, fetch_stall}, 32'd0);
    chk("c3_inst",      inst_out, 32'h0010_0093);
    chk("c3_fcount",    fetch_count, 32'd1);

    // sequential PC 4 with two cycles of backpressure
    pc_in = 32'h4;
    mif.mem_ready = 1'b0;
    #1;
    chk("pc4_stall_comb", {31'd0, fetch_stall}, 32'd1);
    tick();
    chk("pc4_bp1_req",  {31'd0, mif.mem_req}, 32'd1);
    chk("pc4_bp1_addr", mif.mem_addr, 32'h4);
    tick();
    chk("pc4_bp2_req",  {31'd0, mif.mem_req}, 32'd1);
    chk("pc4_bp2_addr", mif.mem_addr, 32'h4);
    mif.mem_ready = 1'b1;
    tick();
    chk("pc4_wait_req", {31'd0, mif.mem_req}, 32'd0);
    tick();
    chk("pc4_stall",    {31'd0, fetch_stall}, 32'd0);
    chk("pc4_inst",     inst_out, mdata(32'h4));

    // PC 8 at minimum latency: 3 stall cycles
    pc_in = 32'h8;
    #1;
    wait_valid(20, n);
    chk("pc8_penalty",  n, 32'd3);
    chk("pc8_inst",     inst_out, mdata(32'h8));
    chk("pc8_fcount",   fetch_count, 32'd3);
    chk("pc8_dcount",   discard_count, 32'd0);

    // redirect 0x10 -> 0x80 while waiting for the response
    pc_in = 32'h10;
    #1;
    tick();
    chk("rd_req_addr",  mif.mem_addr, 32'h10);
    tick();
    chk("rd_wait_req",  {31'd0, mif.mem_req}, 32'd0);
    pc_in = 32'h80;
    #1;
    tick();
    chk("rd_dcount",    discard_count, 32'd1);
    chk("rd_new_req",   {31'd0, mif.mem_req}, 32'd1);
    chk("rd_new_addr",  mif.mem_addr, 32'h80);
    chk("rd_stall",     {31'd0, fetch_stall}, 32'd1);
    wait_valid(20, n);
    chk("rd_penalty",   n, 32'd2);
    chk("rd_inst",      inst_out, mdata(32'h80));
    chk("rd_fcount",    fetch_count, 32'd5);
    chk("rd_dcount2",   discard_count, 32'd1);

    // misaligned PC: one stall cycle, no memory access
    pc_in = 32'h22;
    #1;
    chk("mis_stall0",   {31'd0, fetch_stall}, 32'd1);
    chk("mis_req0",     {31'd0, mif.mem_req}, 32'd0);
    tick();
    chk("mis_stall1",   {31'd0, fetch_stall}, 32'd0);
    chk("mis_inst",     inst_out, 32'h0000_0013);
    chk("mis_req1",     {31'd0, mif.mem_req}, 32'd0);
    chk("mis_fcount",   fetch_count, 32'd5);

    // held PC: no extra requests for 20 cycles
    pc_in = 32'h40;
    #1;
    wait_valid(20, n);
    chk("hold_penalty", n, 32'd3);
    chk("hold_inst0",   inst_out, mdata(32'h40));
    held_inst = inst_out;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_req",   {31'd0, mif.mem_req}, 32'd0);
    end
    chk("hold_fcount",  fetch_count, 32'd6);
    chk("hold_inst",    inst_out, mdata(32'h40));
    chk("hold_stall",   {31'd0, fetch_stall}, 32'd0);

    // reset while in WAIT; the late response lands during IDLE
    resp_delay = 2;
    pc_in = 32'h100;
    #1;
    tick();
    chk("rw_req",       {31'd0, mif.mem_req}, 32'd1);
    tick();
    chk("rw_wait_req",  {31'd0, mif.mem_req}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rw_late_rvalid_seen", {31'd0, mif.mem_rvalid}, 32'd1);
    chk("rw_fcount",    fetch_count, 32'd0);
    chk("rw_dcount",    discard_count, 32'd0);
    chk("rw_stall",     {31'd0, fetch_stall}, 32'd1);
    chk("rw_req_idle",  {31'd0, mif.mem_req}, 32'd0);
    chk("rw_inst",      inst_out, 32'h0);
    resp_delay = 1;
    tick();
    chk("rw_fresh_req", {31'd0, mif.mem_req}, 32'd1);
    chk("rw_fresh_addr", mif.mem_addr, 32'h100);
    chk("rw_dcount2",   discard_count, 32'd0);
    wait_valid(20, n);
    chk("rw_penalty",   n, 32'd2);
    chk("rw_inst2",     inst_out, mdata(32'h100));
    chk("rw_fcount2",   fetch_count, 32'd1);
    chk("rw_dcount3",   discard_count, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
